// File: rtl/alu_op_issuer.sv
// Decodes an RV32 instruction plus register operands into an ALU operation and
// operand pair, and issues it through a registered two-entry skid buffer.
module alu_op_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           Instruction_i,
    input  logic [DATA_WIDTH-1:0] Rs1_Data_i,
    input  logic [DATA_WIDTH-1:0] Rs2_Data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0]            ALU_Operation_o,
    output logic [DATA_WIDTH-1:0] A_o,
    output logic [DATA_WIDTH-1:0] B_o,
    output logic                  Illegal_o,
    output logic [CNT_WIDTH-1:0]  Op_Count_o
);

    // state    | meaning
    // ST_EMPTY | no entry buffered, outputs invalid
    // ST_MAIN  | main entry drives outputs, skid empty
    // ST_FULL  | main entry drives outputs, skid holds the next entry
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_LUI     = 4'b1000;
    localparam logic [3:0] OP_OR      = 4'b1001;
    localparam logic [3:0] OP_SLLI    = 4'b1100;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    occ_e                  state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [3:0]            main_op_q, main_op_d;
    logic [DATA_WIDTH-1:0] main_a_q, main_a_d;
    logic [DATA_WIDTH-1:0] main_b_q, main_b_d;
    logic                  main_ill_q, main_ill_d;
    logic [3:0]            skid_op_q, skid_op_d;
    logic [DATA_WIDTH-1:0] skid_a_q, skid_a_d;
    logic [DATA_WIDTH-1:0] skid_b_q, skid_b_d;
    logic                  skid_ill_q, skid_ill_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [3:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_ill;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       main_valid;
    logic       accept;
    logic       out_hs;
    logic       unused_rd;

    assign opcode    = Instruction_i[6:0];
    assign funct3    = Instruction_i[14:12];
    assign funct7    = Instruction_i[31:25];
    assign unused_rd = ^Instruction_i[11:7];

    // Anything not matched below falls through as an ILLEGAL entry with zero operands.
    always_comb begin
        dec_op  = OP_ILLEGAL;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b1;
        unique case (opcode)
            OPC_REG: begin
                if (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b110)) begin
                    dec_op  = (funct3 == 3'b000) ? OP_ADD : OP_OR;
                    dec_a   = Rs1_Data_i;
                    dec_b   = Rs2_Data_i;
                    dec_ill = 1'b0;
                end
            end
            OPC_IMM: begin
                if (funct3 == 3'b000 || funct3 == 3'b110) begin
                    dec_op  = (funct3 == 3'b000) ? OP_ADD : OP_OR;
                    dec_a   = Rs1_Data_i;
                    dec_b   = {{(DATA_WIDTH-12){Instruction_i[31]}}, Instruction_i[31:20]};
                    dec_ill = 1'b0;
                end else if (funct3 == 3'b001 && funct7 == 7'b0000000) begin
                    dec_op  = OP_SLLI;
                    dec_a   = Rs1_Data_i;
                    dec_b   = {{(DATA_WIDTH-5){1'b0}}, Instruction_i[24:20]};
                    dec_ill = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_op  = OP_LUI;
                dec_a   = '0;
                dec_b   = {{(DATA_WIDTH-20){1'b0}}, Instruction_i[31:12]};
                dec_ill = 1'b0;
            end
            default: begin
                dec_op  = OP_ILLEGAL;
            end
        endcase
    end

    assign main_valid = (state_q != ST_EMPTY);
    assign accept     = in_valid_i & in_ready_q;
    assign out_hs     = main_valid & out_ready_i;

    always_comb begin
        state_d    = state_q;
        main_op_d  = main_op_q;
        main_a_d   = main_a_q;
        main_b_d   = main_b_q;
        main_ill_d = main_ill_q;
        skid_op_d  = skid_op_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
        skid_ill_d = skid_ill_q;
        cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, out_hs};

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_op_d  = dec_op;
                    main_a_d   = dec_a;
                    main_b_d   = dec_b;
                    main_ill_d = dec_ill;
                    state_d    = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (accept && out_hs) begin
                    main_op_d  = dec_op;
                    main_a_d   = dec_a;
                    main_b_d   = dec_b;
                    main_ill_d = dec_ill;
                end else if (accept) begin
                    skid_op_d  = dec_op;
                    skid_a_d   = dec_a;
                    skid_b_d   = dec_b;
                    skid_ill_d = dec_ill;
                    state_d    = ST_FULL;
                end else if (out_hs) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no accept can race the skid promotion.
                if (out_hs) begin
                    main_op_d  = skid_op_q;
                    main_a_d   = skid_a_q;
                    main_b_d   = skid_b_q;
                    main_ill_d = skid_ill_q;
                    state_d    = ST_MAIN;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush_i) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_op_q  <= '0;
            main_a_q   <= '0;
            main_b_q   <= '0;
            main_ill_q <= 1'b0;
            skid_op_q  <= '0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_ill_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_op_q  <= main_op_d;
            main_a_q   <= main_a_d;
            main_b_q   <= main_b_d;
            main_ill_q <= main_ill_d;
            skid_op_q  <= skid_op_d;
            skid_a_q   <= skid_a_d;
            skid_b_q   <= skid_b_d;
            skid_ill_q <= skid_ill_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = main_valid;
    assign ALU_Operation_o = main_op_q;
    assign A_o             = main_a_q;
    assign B_o             = main_b_q;
    assign Illegal_o       = main_ill_q;
    assign Op_Count_o      = cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: expected entries are queued on accept and
// compared in order as the issuer hands them to the ALU side.
module tb_alu_op_issuer;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] Instruction_i;
    logic [31:0] Rs1_Data_i;
    logic [31:0] Rs2_Data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  ALU_Operation_o;
    logic [31:0] A_o;
    logic [31:0] B_o;
    logic        Illegal_o;
    logic [15:0] Op_Count_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    alu_op_issuer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .Instruction_i   (Instruction_i),
        .Rs1_Data_i      (Rs1_Data_i),
        .Rs2_Data_i      (Rs2_Data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .ALU_Operation_o (ALU_Operation_o),
        .A_o             (A_o),
        .B_o             (B_o),
        .Illegal_o       (Illegal_o),
        .Op_Count_o      (Op_Count_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; the monitor decides whether it was taken.
    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
                         input logic e_ill);
        Instruction_i = instr;
        Rs1_Data_i    = rs1;
        Rs2_Data_i    = rs2;
        pend          = '{op: e_op, a: e_a, b: e_b, ill: e_ill};
        in_valid_i    = 1'b1;
        cyc();
        in_valid_i    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            check("op_count", Op_Count_o, exp_cnt);
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_valid_o, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("alu_op", ALU_Operation_o, e.op);
                    check("a_val", A_o, e.a);
                    check("b_val", B_o, e.b);
                    check("illegal", Illegal_o, e.ill);
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            if (flush_i) sb.delete();
            else if (in_valid_i && in_ready_o) sb.push_back(pend);
        end
    end

    initial begin
        reset = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        Instruction_i = '0; Rs1_Data_i = '0; Rs2_Data_i = '0; pend = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_op", ALU_Operation_o, 0);
        check("rst_a", A_o, 0);
        check("rst_b", B_o, 0);
        check("rst_ill", Illegal_o, 0);
        check("rst_cnt", Op_Count_o, 0);
        cyc();
        reset = 1'b1;

        // add, then one-cycle latency to the outputs
        issue(32'h002081B3, 32'd5, 32'd7, 4'b0000, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        check("add_latency_valid", out_valid_o, 1);
        check("add_latency_a", A_o, 5);
        cyc();

        // back-to-back burst covering every decode class
        issue(32'hFFF10293, 32'd10,    32'd0,  4'b0000, 32'd10,    32'hFFFFFFFF, 1'b0);
        issue(32'h0F00E313, 32'h100,   32'd0,  4'b1001, 32'h100,   32'h000000F0, 1'b0);
        issue(32'h123453B7, 32'hDEAD,  32'd1,  4'b1000, 32'd0,     32'h00012345, 1'b0);
        issue(32'h00409413, 32'd1,     32'd0,  4'b1100, 32'd1,     32'd4,        1'b0);
        issue(32'h0020E1B3, 32'hA0,    32'h0B, 4'b1001, 32'hA0,    32'h0B,       1'b0);
        issue(32'h402081B3, 32'h55,    32'h66, 4'b1111, 32'd0,     32'd0,        1'b1);
        issue(32'h00002083, 32'h77,    32'h88, 4'b1111, 32'd0,     32'd0,        1'b1);
        issue(32'h40409413, 32'h99,    32'd0,  4'b1111, 32'd0,     32'd0,        1'b1);
        repeat (2) cyc();
        @(negedge clk);
        check("cnt_after_burst", Op_Count_o, 9);
        check("burst_drained", out_valid_o, 0);
        cyc();

        // back-pressure: two taken, third refused
        out_ready_i = 1'b0;
        issue(32'h002081B3, 32'h11, 32'h22, 4'b0000, 32'h11, 32'h22, 1'b0);
        issue(32'h0020E1B3, 32'h33, 32'h44, 4'b1001, 32'h33, 32'h44, 1'b0);
        @(negedge clk);
        check("stall_in_ready_low", in_ready_o, 0);
        issue(32'h123453B7, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h00012345, 1'b0);
        @(negedge clk);
        check("stall_valid", out_valid_o, 1);
        check("stall_hold_a", A_o, 32'h11);
        check("stall_hold_b", B_o, 32'h22);
        check("stall_in_ready_still_low", in_ready_o, 0);
        cyc();
        out_ready_i = 1'b1;
        cyc();
        @(negedge clk);
        check("release_in_ready", in_ready_o, 1);
        check("release_second_valid", out_valid_o, 1);
        cyc();
        @(negedge clk);
        check("release_drained", out_valid_o, 0);
        check("cnt_after_release", Op_Count_o, 11);
        cyc();

        // flush while a handshake completes: still counted
        issue(32'h00510293, 32'd3, 32'd0, 4'b0000, 32'd3, 32'd5, 1'b0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_hs_valid", out_valid_o, 0);
        check("flush_hs_cnt", Op_Count_o, 12);
        cyc();

        // flush with both entries buffered
        out_ready_i = 1'b0;
        issue(32'h002081B3, 32'h1, 32'h2, 4'b0000, 32'h1, 32'h2, 1'b0);
        issue(32'h002081B3, 32'h3, 32'h4, 4'b0000, 32'h3, 32'h4, 1'b0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_full_valid", out_valid_o, 0);
        check("flush_full_in_ready", in_ready_o, 1);
        cyc();

        // accept coinciding with flush is discarded
        issue(32'h002081B3, 32'h5, 32'h6, 4'b0000, 32'h5, 32'h6, 1'b0);
        flush_i = 1'b1;
        issue(32'h002081B3, 32'h7, 32'h8, 4'b0000, 32'h7, 32'h8, 1'b0);
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_accept_valid", out_valid_o, 0);
        check("flush_accept_in_ready", in_ready_o, 1);
        cyc();
        out_ready_i = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        check("flush_no_stray", out_valid_o, 0);
        check("cnt_after_flush", Op_Count_o, 12);
        cyc();

        // reset while stalled with two entries
        out_ready_i = 1'b0;
        issue(32'h002081B3, 32'hAA, 32'hBB, 4'b0000, 32'hAA, 32'hBB, 1'b0);
        issue(32'h002081B3, 32'hCC, 32'hDD, 4'b0000, 32'hCC, 32'hDD, 1'b0);
        reset = 1'b0;
        cyc();
        @(negedge clk);
        check("midrst_valid", out_valid_o, 0);
        check("midrst_in_ready", in_ready_o, 1);
        check("midrst_op", ALU_Operation_o, 0);
        check("midrst_a", A_o, 0);
        check("midrst_b", B_o, 0);
        check("midrst_ill", Illegal_o, 0);
        check("midrst_cnt", Op_Count_o, 0);
        cyc();
        reset = 1'b1;
        out_ready_i = 1'b1;
        issue(32'h002081B3, 32'd5, 32'd7, 4'b0000, 32'd5, 32'd7, 1'b0);

        for (int i = 0; i < 20 && out_valid_o; i++) cyc();
        cyc();
        @(negedge clk);
        check("final_idle", out_valid_o, 0);
        check("final_cnt", Op_Count_o, 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
